decoder4_10_pipe: RTL and testbench

// - Inverse of the 10-to-4 encoder: turns a 4-bit code 0..9 back into a 10-bit pattern.
// - mode_sel=0 gives a one-hot pattern. Feeding it to the encoder in normal mode returns the code.
// - mode_sel=1 gives a thermometer pattern. Feeding it to the encoder in priority mode returns the code.
// - Single registered output stage with valid/ready on both sides; sits between a code source and a pattern sink.
// - Flags illegal codes (10..15) and keeps a saturating error count.

---
 rtl/decoder4_10_pipe.sv | 87 ++++++++
 tb/tb_decoder4_10_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder4_10_pipe.sv
// 4-bit code to 10-bit one-hot / thermometer decoder with one registered
// output stage, valid/ready handshakes on both sides and a saturating error count.
module decoder4_10_pipe #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [3:0]           din,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode_sel,
    output logic [9:0]           dout,
    output logic                 out_en,
    input  logic                 out_ready,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    logic                 out_en_q, out_en_d;
    logic [9:0]           dout_q, dout_d;
    logic                 out_err_q, out_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 alive_q;
    logic                 accept, illegal;

    function automatic logic [9:0] decode_code(input logic [3:0] code, input logic thermo);
        logic [9:0] pat;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            if (thermo) pat[i] = (4'(i) <= code);
            else        pat[i] = (4'(i) == code);
        end
        return pat;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    // alive_q keeps in_ready low while rst_n is held without feeding rst_n into datapath logic
    assign in_ready = alive_q && en && (!out_en_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign illegal  = (din > 4'd9);

    always_comb begin
        out_en_d  = out_en_q;
        dout_d    = dout_q;
        out_err_d = out_err_q;
        err_cnt_d = err_cnt_q;

        if (accept) begin
            out_en_d  = 1'b1;
            dout_d    = illegal ? 10'd0 : decode_code(din, mode_sel);
            out_err_d = illegal;
        end else if (out_en_q && out_ready) begin
            out_en_d  = 1'b0;
        end

        if (err_clr)                err_cnt_d = '0;
        else if (accept && illegal) err_cnt_d = sat_inc(err_cnt_q);
    end

    // output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q   <= 1'b0;
            out_en_q  <= 1'b0;
            dout_q    <= '0;
            out_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            alive_q   <= 1'b1;
            out_en_q  <= out_en_d;
            dout_q    <= dout_d;
            out_err_q <= out_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_en  = out_en_q;
    assign dout    = dout_q;
    assign out_err = out_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_decoder4_10_pipe.sv
// Self-checking bench for decoder4_10_pipe: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_decoder4_10_pipe;

    logic       clk = 1'b0;
    logic       rst_n, en, in_valid, mode_sel, out_ready, err_clr;
    logic [3:0] din;
    logic       in_ready, out_en, out_err;
    logic [9:0] dout;
    logic [7:0] err_cnt;

    logic       s_en, s_in_valid, s_mode, s_out_ready, s_err_clr;
    logic [3:0] s_din;
    logic       s_in_ready, s_out_en, s_out_err;
    logic [9:0] s_dout;
    logic [1:0] s_err_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    decoder4_10_pipe #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .in_valid(in_valid),
        .in_ready(in_ready), .mode_sel(mode_sel), .dout(dout), .out_en(out_en),
        .out_ready(out_ready), .out_err(out_err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    decoder4_10_pipe #(.ERR_CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(s_en), .din(s_din), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .mode_sel(s_mode), .dout(s_dout), .out_en(s_out_en),
        .out_ready(s_out_ready), .out_err(s_out_err), .err_cnt(s_err_cnt), .err_clr(s_err_clr)
    );

    // Reference pattern from plain arithmetic: 2**code or 2**(code+1)-1.
    function automatic logic [9:0] ref_pattern(input int code, input int mode);
        if (code > 9) return 10'd0;
        if (mode != 0) return 10'((1 << (code + 1)) - 1);
        return 10'(1 << code);
    endfunction

    // Encoder10_4 behaviour: normal mode needs exactly one set bit.
    function automatic int enc_normal(input logic [9:0] p);
        if ($countones(p) != 1) return -1;
        for (int i = 0; i < 10; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic int enc_prio(input logic [9:0] p);
        for (int i = 9; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int waited;
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; din = 4'd3; mode_sel = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (3) tick();
        checks++; if (out_en !== 1'b0) $display("FAIL reset_out_en: got %0b want 0", out_en); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else passes++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else passes++;
        checks++; if (dout !== 10'd0 || out_err !== 1'b0)
            $display("FAIL reset_dout: got %b/%0b want 0/0", dout, out_err); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        waited = 0;
        #1;
        while (in_ready !== 1'b1 && waited < 5) begin
            tick();
            waited++;
        end
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready_timeout: got %0b want 1", in_ready); else passes++;
        checks++; if (out_en !== 1'b0) $display("FAIL reset_pre_accept: got %0b want 0", out_en); else passes++;
        tick();
        checks++; if (out_en !== 1'b1 || dout !== ref_pattern(3, 0))
            $display("FAIL reset_first_beat: got %0b/%b want 1/%b", out_en, dout, ref_pattern(3, 0)); else passes++;
        in_valid = 1'b0;
        tick();
        checks++; if (out_en !== 1'b0) $display("FAIL reset_drain: got %0b want 0", out_en); else passes++;
    endtask

    task automatic test_sweep();
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 10; d++) begin
                mode_sel = m[0]; din = 4'(d);
                tick();
                checks++; if (out_en !== 1'b1 || dout !== ref_pattern(d, m) || out_err !== 1'b0)
                    $display("FAIL sweep m%0d d%0d: got %0b/%b/%0b want 1/%b/0", m, d, out_en, dout, out_err, ref_pattern(d, m));
                else passes++;
                checks++; if (in_ready !== 1'b1) $display("FAIL sweep_ready m%0d d%0d: got %0b want 1", m, d, in_ready); else passes++;
            end
        end
        checks++; if (ref_pattern(5, 0) !== 10'b00_0010_0000 || ref_pattern(5, 1) !== 10'b00_0011_1111)
            $display("FAIL sweep_ref5: got %b/%b", ref_pattern(5, 0), ref_pattern(5, 1)); else passes++;
        in_valid = 1'b0;
        tick();
        checks++; if (out_en !== 1'b0) $display("FAIL sweep_drain: got %0b want 0", out_en); else passes++;
    endtask

    task automatic test_round_trip();
        int code;
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 10; d++) begin
                mode_sel = m[0]; din = 4'(d);
                tick();
                code = (m == 0) ? enc_normal(dout) : enc_prio(dout);
                checks++; if (out_en !== 1'b1 || code != d)
                    $display("FAIL round_trip m%0d: got %0d want %0d", m, code, d); else passes++;
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_cnt !== 8'd0) $display("FAIL illegal_clr: got %0d want 0", err_cnt); else passes++;
        for (int d = 10; d < 16; d++) begin
            din = 4'(d); mode_sel = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            tick();
            checks++; if (out_en !== 1'b1 || dout !== 10'd0 || out_err !== 1'b1)
                $display("FAIL illegal d%0d: got %0b/%b/%0b want 1/0/1", d, out_en, dout, out_err); else passes++;
        end
        checks++; if (err_cnt !== 8'd6) $display("FAIL illegal_count: got %0d want 6", err_cnt); else passes++;
        din = 4'd12; err_clr = 1'b1;
        tick();
        checks++; if (err_cnt !== 8'd0 || out_err !== 1'b1)
            $display("FAIL illegal_clr_wins: got %0d/%0b want 0/1", err_cnt, out_err); else passes++;
        err_clr = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        s_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_din = 4'($urandom_range(10, 15));
            tick();
        end
        s_in_valid = 1'b0;
        checks++; if (s_err_cnt !== 2'd3 || s_out_err !== 1'b1)
            $display("FAIL saturate: got %0d/%0b want 3/1", s_err_cnt, s_out_err); else passes++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [9:0] exp_seq [3];
        en = 1'b1; out_ready = 1'b0; in_valid = 1'b1; mode_sel = 1'b0; din = 4'd1;
        tick();
        din = 4'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_en !== 1'b1 || dout !== ref_pattern(1, 0) || in_ready !== 1'b0)
                $display("FAIL backpressure_hold%0d: got %0b/%b/%0b want 1/%b/0", k, out_en, dout, in_ready, ref_pattern(1, 0));
            else passes++;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL backpressure_release: got %0b want 1", in_ready); else passes++;
        exp_seq[0] = ref_pattern(2, 0); exp_seq[1] = ref_pattern(3, 0); exp_seq[2] = ref_pattern(4, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_en !== 1'b1 || dout !== exp_seq[k])
                $display("FAIL backpressure_order%0d: got %0b/%b want 1/%b", k, out_en, dout, exp_seq[k]); else passes++;
            din = 4'(3 + k);
            if (k == 2) in_valid = 1'b0;
        end
        tick();
        checks++; if (out_en !== 1'b0) $display("FAIL backpressure_drain: got %0b want 0", out_en); else passes++;
    endtask

    task automatic test_enable();
        en = 1'b1; out_ready = 1'b0; in_valid = 1'b1; mode_sel = 1'b1; din = 4'd7;
        tick();
        checks++; if (dout !== ref_pattern(7, 1)) $display("FAIL enable_first: got %b want %b", dout, ref_pattern(7, 1)); else passes++;
        en = 1'b0; din = 4'd8;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL enable_gate: got %0b want 0", in_ready); else passes++;
        tick();
        checks++; if (out_en !== 1'b1 || dout !== ref_pattern(7, 1))
            $display("FAIL enable_hold: got %0b/%b want 1/%b", out_en, dout, ref_pattern(7, 1)); else passes++;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL enable_gate_ready: got %0b want 0", in_ready); else passes++;
        tick();
        checks++; if (out_en !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL enable_drain: got %0b/%0b want 0/0", out_en, in_ready); else passes++;
        en = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL enable_resume_ready: got %0b want 1", in_ready); else passes++;
        tick();
        checks++; if (out_en !== 1'b1 || dout !== ref_pattern(8, 1))
            $display("FAIL enable_resume: got %0b/%b want 1/%b", out_en, dout, ref_pattern(8, 1)); else passes++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [10:0] q[$];
        int          cnt_m;
        logic        exp_ready;
        in_valid = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        cnt_m = 0;
        for (int c = 0; c < 400; c++) begin
            en        = ($urandom_range(0, 7) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            din       = 4'($urandom_range(0, 15));
            mode_sel  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 31) == 0);
            #1;
            exp_ready = en && (q.size() == 0 || out_ready);
            checks++; if (in_ready !== exp_ready)
                $display("FAIL rand_ready c%0d: got %0b want %0b", c, in_ready, exp_ready); else passes++;
            checks++;
            if (q.size() == 0) begin
                if (out_en !== 1'b0) $display("FAIL rand_empty c%0d: got %0b want 0", c, out_en); else passes++;
            end else begin
                if (out_en !== 1'b1 || {out_err, dout} !== q[0])
                    $display("FAIL rand_beat c%0d: got %0b/%h want 1/%h", c, out_en, {out_err, dout}, q[0]);
                else passes++;
            end
            checks++; if (err_cnt !== 8'(cnt_m))
                $display("FAIL rand_err_cnt c%0d: got %0d want %0d", c, err_cnt, cnt_m); else passes++;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) q.push_back({din > 4'd9, ref_pattern(int'(din), int'(mode_sel))});
            if (err_clr) cnt_m = 0;
            else if (in_valid && exp_ready && din > 4'd9 && cnt_m < 255) cnt_m++;
            tick();
        end
        in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1; en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1; din = 4'd11;
        tick();
        in_valid = 1'b0;
        checks++; if (out_en !== 1'b1 || err_cnt !== 8'd1)
            $display("FAIL reset_mid_pending: got %0b/%0d want 1/1", out_en, err_cnt); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_en !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b0)
            $display("FAIL reset_mid_async: got %0b/%0d/%0b want 0/0/0", out_en, err_cnt, in_ready); else passes++;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (out_en !== 1'b0) $display("FAIL reset_mid_quiet: got %0b want 0", out_en); else passes++;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; mode_sel = 1'b0; out_ready = 1'b0;
        err_clr = 1'b0; din = 4'd0;
        s_en = 1'b1; s_in_valid = 1'b0; s_mode = 1'b0; s_out_ready = 1'b1; s_err_clr = 1'b0; s_din = 4'd0;
        test_reset();
        test_sweep();
        test_round_trip();
        test_illegal();
        test_saturate();
        test_backpressure();
        test_enable();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
